// File: rtl/qoi_decode_ctrl.sv
// Purpose: QOI chunk sequencer that parses opcodes and tracks prev pixel, 64-entry index and run count.
// Latency: a pixel is valid one cycle after the last byte of its chunk; run pixels follow back-to-back.
// Backpressure: out_pixel is held until out_ready; no input byte is accepted while out_valid is high.
module qoi_decode_ctrl #(
    parameter bit CLEAR_INDEX_ON_START = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [29:0] num_pixels,
    output logic        busy,
    output logic        done,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_pixel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  cur_op
);

    // One-hot opcode identifiers exposed on cur_op.
    localparam logic [5:0] OP_RGB   = 6'b000001;
    localparam logic [5:0] OP_RGBA  = 6'b000010;
    localparam logic [5:0] OP_INDEX = 6'b000100;
    localparam logic [5:0] OP_DIFF  = 6'b001000;
    localparam logic [5:0] OP_LUMA  = 6'b010000;
    localparam logic [5:0] OP_RUN   = 6'b100000;

    localparam logic [31:0] PREV_INIT = 32'hFF00_0000;

    typedef enum logic [2:0] {
        S_IDLE, S_OPC, S_ARGS, S_EMIT, S_RUN, S_DONE
    } state_t;

    state_t      state, state_d;
    logic [29:0] num_lat;
    logic [29:0] pix_cnt;
    logic [31:0] prev;
    logic [5:0]  run_cnt;
    logic [1:0]  arg_idx;
    logic [7:0]  arg0, arg1, arg2;
    logic [5:0]  opc_lo;
    logic [31:0] idx_mem [64];
    logic [63:0] idx_vld;

    logic        init, op_ld, emit_ld, run_ld, run_dec, arg_wr, commit, ov_clr;
    logic [5:0]  op_d;
    logic [31:0] pix_d;

    logic        in_xfer, out_xfer, last;
    logic [7:0]  prev_r, prev_g, prev_b, prev_a;
    logic [7:0]  d_r, d_g, d_b;
    logic [7:0]  l_dg, l_r, l_g, l_b;
    logic [31:0] idx_rd;
    logic [5:0]  hash;
    logic [1:0]  arg_last;

    assign busy     = (state == S_OPC) || (state == S_ARGS) || (state == S_EMIT) || (state == S_RUN);
    assign done     = (state == S_DONE);
    assign in_ready = ((state == S_OPC) || (state == S_ARGS)) && !out_valid;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign last     = (pix_cnt + 30'd1) == num_lat;

    assign prev_r = prev[7:0];
    assign prev_g = prev[15:8];
    assign prev_b = prev[23:16];
    assign prev_a = prev[31:24];

    // Small signed deltas biased by 2 (DIFF) and by 32 / 8 (LUMA); 8-bit wrap is intentional.
    assign d_r  = prev_r + {6'b0, in_data[5:4]} - 8'd2;
    assign d_g  = prev_g + {6'b0, in_data[3:2]} - 8'd2;
    assign d_b  = prev_b + {6'b0, in_data[1:0]} - 8'd2;
    assign l_dg = {2'b00, opc_lo} - 8'd32;
    assign l_r  = prev_r + l_dg + {4'b0, in_data[7:4]} - 8'd8;
    assign l_g  = prev_g + l_dg;
    assign l_b  = prev_b + l_dg + {4'b0, in_data[3:0]} - 8'd8;

    assign idx_rd = idx_vld[in_data[5:0]] ? idx_mem[in_data[5:0]] : 32'h0;

    // Only the low 6 bits of each channel matter for a mod-64 hash.
    assign hash = out_pixel[5:0]   * 6'd3 + out_pixel[13:8]  * 6'd5
                + out_pixel[21:16] * 6'd7 + out_pixel[29:24] * 6'd11;

    assign arg_last = (cur_op == OP_RGBA) ? 2'd3 : (cur_op == OP_RGB) ? 2'd2 : 2'd0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_d = state;
        init    = 1'b0;
        op_ld   = 1'b0;
        op_d    = cur_op;
        emit_ld = 1'b0;
        pix_d   = out_pixel;
        run_ld  = 1'b0;
        run_dec = 1'b0;
        arg_wr  = 1'b0;
        commit  = 1'b0;
        ov_clr  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    init    = 1'b1;
                    state_d = (num_pixels == 30'd0) ? S_DONE : S_OPC;
                end
            end
            S_OPC: begin
                if (in_xfer) begin
                    op_ld = 1'b1;
                    if (in_data == 8'hFE) begin
                        op_d    = OP_RGB;
                        state_d = S_ARGS;
                    end else if (in_data == 8'hFF) begin
                        op_d    = OP_RGBA;
                        state_d = S_ARGS;
                    end else begin
                        case (in_data[7:6])
                            2'b00: begin
                                op_d    = OP_INDEX;
                                emit_ld = 1'b1;
                                pix_d   = idx_rd;
                                state_d = S_EMIT;
                            end
                            2'b01: begin
                                op_d    = OP_DIFF;
                                emit_ld = 1'b1;
                                pix_d   = {prev_a, d_b, d_g, d_r};
                                state_d = S_EMIT;
                            end
                            2'b10: begin
                                op_d    = OP_LUMA;
                                state_d = S_ARGS;
                            end
                            default: begin
                                op_d    = OP_RUN;
                                emit_ld = 1'b1;
                                pix_d   = prev;
                                run_ld  = 1'b1;
                                state_d = S_RUN;
                            end
                        endcase
                    end
                end
            end
            S_ARGS: begin
                if (in_xfer) begin
                    arg_wr = 1'b1;
                    if (arg_idx == arg_last) begin
                        emit_ld = 1'b1;
                        state_d = S_EMIT;
                        case (cur_op)
                            OP_RGB:  pix_d = {prev_a, in_data, arg1, arg0};
                            OP_RGBA: pix_d = {in_data, arg2, arg1, arg0};
                            default: pix_d = {prev_a, l_b, l_g, l_r};
                        endcase
                    end
                end
            end
            S_EMIT: begin
                if (out_xfer) begin
                    commit  = 1'b1;
                    ov_clr  = 1'b1;
                    state_d = last ? S_DONE : S_OPC;
                end
            end
            S_RUN: begin
                if (out_xfer) begin
                    commit = 1'b1;
                    if (last) begin
                        ov_clr  = 1'b1;
                        state_d = S_DONE;
                    end else if (run_cnt == 6'd0) begin
                        ov_clr  = 1'b1;
                        state_d = S_OPC;
                    end else begin
                        run_dec = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Chunk bookkeeping: opcode, argument bytes, run length, pixel count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_op  <= OP_RGB;
            opc_lo  <= 6'd0;
            arg_idx <= 2'd0;
            arg0    <= 8'd0;
            arg1    <= 8'd0;
            arg2    <= 8'd0;
            run_cnt <= 6'd0;
            num_lat <= 30'd0;
            pix_cnt <= 30'd0;
        end else begin
            if (init) begin
                num_lat <= num_pixels;
                pix_cnt <= 30'd0;
            end else if (commit) begin
                pix_cnt <= pix_cnt + 30'd1;
            end
            if (op_ld) begin
                cur_op  <= op_d;
                opc_lo  <= in_data[5:0];
                arg_idx <= 2'd0;
            end else if (arg_wr) begin
                arg_idx <= arg_idx + 2'd1;
                case (arg_idx)
                    2'd0:    arg0 <= in_data;
                    2'd1:    arg1 <= in_data;
                    default: arg2 <= in_data;
                endcase
            end
            if (run_ld)       run_cnt <= in_data[5:0];
            else if (run_dec) run_cnt <= run_cnt - 6'd1;
        end
    end

    // Output pixel register, previous pixel and index valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pixel <= 32'h0;
            out_valid <= 1'b0;
            prev      <= PREV_INIT;
            idx_vld   <= 64'h0;
        end else begin
            if (emit_ld) begin
                out_pixel <= pix_d;
                out_valid <= 1'b1;
            end else if (ov_clr) begin
                out_valid <= 1'b0;
            end
            if (init) begin
                prev <= PREV_INIT;
                if (CLEAR_INDEX_ON_START) idx_vld <= 64'h0;
            end else if (commit) begin
                prev          <= out_pixel;
                idx_vld[hash] <= 1'b1;
            end
        end
    end

    // Index storage; entries are qualified by idx_vld so no reset is needed.
    always_ff @(posedge clk) begin
        if (commit) idx_mem[hash] <= out_pixel;
    end

endmodule

// File: tb/tb_qoi_decode_ctrl.sv
module tb_qoi_decode_ctrl;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] pq_t[$];
    typedef int          iq_t[$];

    localparam logic [5:0] OP_RGB  = 6'b000001;
    localparam logic [5:0] OP_RGBA = 6'b000010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [29:0] num_pixels;
    logic        busy, done;
    logic [7:0]  in_data;
    logic        in_valid, in_ready;
    logic [31:0] out_pixel;
    logic        out_valid, out_ready;
    logic [5:0]  cur_op;

    int n_cmp = 0;
    int n_bad = 0;

    qoi_decode_ctrl #(.CLEAR_INDEX_ON_START(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_pixels(num_pixels),
        .busy(busy), .done(done), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_pixel(out_pixel), .out_valid(out_valid),
        .out_ready(out_ready), .cur_op(cur_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decoder: walks the chunk stream with plain integer channel math.
    task automatic model(input bq_t s, output pq_t px, output iq_t endo);
        int r, g, b, a, i, op, cnt, dg, b1, h;
        logic [31:0] idx [64];
        logic [31:0] p;
        r = 0; g = 0; b = 0; a = 255; i = 0;
        px = {}; endo = {};
        for (int k = 0; k < 64; k++) idx[k] = 32'h0;
        while (i < s.size()) begin
            op = int'(s[i]); i++; cnt = 1;
            if (op == 254) begin
                r = int'(s[i]); g = int'(s[i+1]); b = int'(s[i+2]); i += 3;
            end else if (op == 255) begin
                r = int'(s[i]); g = int'(s[i+1]); b = int'(s[i+2]); a = int'(s[i+3]); i += 4;
            end else begin
                case (op >> 6)
                    0: begin
                        p = idx[op & 63];
                        r = int'(p[7:0]); g = int'(p[15:8]); b = int'(p[23:16]); a = int'(p[31:24]);
                    end
                    1: begin
                        r = (r + ((op >> 4) & 3) - 2) & 255;
                        g = (g + ((op >> 2) & 3) - 2) & 255;
                        b = (b + (op & 3) - 2) & 255;
                    end
                    2: begin
                        dg = (op & 63) - 32;
                        b1 = int'(s[i]); i++;
                        r = (r + dg + (b1 >> 4) - 8) & 255;
                        g = (g + dg) & 255;
                        b = (b + dg + (b1 & 15) - 8) & 255;
                    end
                    default: cnt = (op & 63) + 1;
                endcase
            end
            for (int c = 0; c < cnt; c++) begin
                p = {a[7:0], b[7:0], g[7:0], r[7:0]};
                px.push_back(p);
                endo.push_back(i);
                h = (3*r + 5*g + 7*b + 11*a) % 64;
                idx[h] = p;
            end
        end
    endtask

    // mode 0: always ready; mode 1: random gaps on both sides; mode 2: sink stalls for 5 cycles.
    task automatic run_img(input string tag, input bq_t s_in, input int n, input pq_t exp,
                           input int used, input int mode, input bit poke);
        bq_t s;
        int ptr, got, cyc;
        bit p_ov, p_ordy, p_ix, fin;
        logic [31:0] p_pix;
        s = s_in;
        for (int k = 0; k < 7; k++) s.push_back(8'h00);
        s.push_back(8'h01);
        ptr = 0; got = 0; cyc = 0; p_ov = 0; p_ordy = 1; p_ix = 0; fin = 0; p_pix = 32'h0;
        @(negedge clk);
        start = 1'b1; num_pixels = n[29:0]; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!fin) begin
            if (got == n) begin
                chk({tag, " done"}, 32'(done), 32'd1);
                fin = 1;
            end else if (cyc > 8000) begin
                chk({tag, " timeout"}, 32'(got), 32'(n));
                fin = 1;
            end else begin
                in_valid  = (ptr < s.size()) && (mode != 1 || $urandom_range(0, 9) < 7);
                in_data   = (ptr < s.size()) ? s[ptr] : 8'h00;
                out_ready = (mode == 0) ? 1'b1 :
                            (mode == 1) ? ($urandom_range(0, 9) < 6) :
                            !(cyc >= 6 && cyc < 11);
                if (poke) begin
                    start      = (cyc == 2);
                    num_pixels = (cyc == 2) ? 30'd7 : n[29:0];
                end
                if (p_ov && !p_ordy) begin
                    chk({tag, " hold valid"}, 32'(out_valid), 32'd1);
                    chk({tag, " hold pixel"}, out_pixel, p_pix);
                end
                if (out_valid && !p_ov) chk({tag, " latency"}, 32'(p_ix), 32'd1);
                if (out_valid) chk({tag, " in_ready blocked"}, 32'(in_ready), 32'd0);
                p_ix = in_valid && in_ready;
                if (p_ix) ptr++;
                if (out_valid && out_ready) begin
                    if (got < exp.size()) chk({tag, " pixel"}, out_pixel, exp[got]);
                    else chk({tag, " extra pixel"}, 32'(got), 32'(exp.size()));
                    got++;
                end
                p_ov = out_valid; p_ordy = out_ready; p_pix = out_pixel;
                cyc++;
                @(negedge clk);
            end
        end
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h00;
        chk({tag, " bytes used"}, 32'(ptr), 32'(used));
        chk({tag, " in_ready in done"}, 32'(in_ready), 32'd0);
        chk({tag, " busy in done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, " done held"}, 32'(done), 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        bq_t q;
        pq_t e, px;
        iq_t endo;
        int n, nch, used;

        rst_n = 1'b0; start = 1'b0; num_pixels = 30'd0;
        in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_pixel", out_pixel, 32'h0);
        chk("rst cur_op", 32'(cur_op), 32'(OP_RGB));
        rst_n = 1'b1;
        @(negedge clk);

        q = '{8'hFE, 8'h10, 8'h20, 8'h30};
        e = '{32'hFF302010};
        run_img("rgb", q, 1, e, 4, 0, 1'b0);

        q = '{8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'hC2};
        e = '{32'h04030201, 32'h04030201, 32'h04030201, 32'h04030201};
        run_img("rgba_run", q, 4, e, 6, 0, 1'b0);

        q = '{8'hFE, 8'h0A, 8'h0B, 8'h0C, 8'h6B};
        e = '{32'hFF0C0B0A, 32'hFF0D0B0A};
        run_img("diff", q, 2, e, 5, 0, 1'b0);

        q = '{8'hFE, 8'h00, 8'h00, 8'h00, 8'h40};
        e = '{32'hFF000000, 32'hFFFEFEFE};
        run_img("wrap", q, 2, e, 5, 1, 1'b0);

        q = '{8'hFE, 8'h10, 8'h20, 8'h30, 8'hA2, 8'h88, 8'h33};
        e = '{32'hFF302010, 32'hFF322212, 32'hFF322212};
        run_img("luma_idx", q, 3, e, 7, 0, 1'b0);

        q = '{8'hFE, 8'h01, 8'h02, 8'h03, 8'hC8};
        e = {};
        for (int k = 0; k < 10; k++) e.push_back(32'hFF030201);
        run_img("backpressure", q, 10, e, 5, 2, 1'b1);

        q = '{8'hFE, 8'h05, 8'h06, 8'h07, 8'hFD};
        e = {};
        for (int k = 0; k < 5; k++) e.push_back(32'hFF070605);
        run_img("truncate", q, 5, e, 5, 1, 1'b0);

        q = {};
        e = {};
        run_img("zero", q, 0, e, 0, 0, 1'b0);

        // Reset in the middle of an RGBA chunk, then a clean image.
        @(negedge clk);
        start = 1'b1; num_pixels = 30'd1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
        @(negedge clk);
        in_data = 8'h11;
        @(negedge clk);
        in_data = 8'h22;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid cur_op", 32'(cur_op), 32'(OP_RGBA));
        chk("mid busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst done", 32'(done), 32'd0);
        chk("arst in_ready", 32'(in_ready), 32'd0);
        chk("arst out_valid", 32'(out_valid), 32'd0);
        chk("arst out_pixel", out_pixel, 32'h0);
        chk("arst cur_op", 32'(cur_op), 32'(OP_RGB));
        @(negedge clk);
        rst_n = 1'b1;
        q = '{8'hFE, 8'h10, 8'h20, 8'h30};
        e = '{32'hFF302010};
        run_img("after_rst", q, 1, e, 4, 0, 1'b0);

        // Randomised chunk streams against the reference decoder.
        for (int t = 0; t < 20; t++) begin
            q = {};
            nch = $urandom_range(1, 10);
            for (int c = 0; c < nch; c++) begin
                case ($urandom_range(0, 5))
                    0: begin
                        q.push_back(8'hFE);
                        for (int k = 0; k < 3; k++) q.push_back(8'($urandom));
                    end
                    1: begin
                        q.push_back(8'hFF);
                        for (int k = 0; k < 4; k++) q.push_back(8'($urandom));
                    end
                    2: q.push_back(8'($urandom_range(0, 63)));
                    3: q.push_back(8'h40 | 8'($urandom_range(0, 63)));
                    4: begin
                        q.push_back(8'h80 | 8'($urandom_range(0, 63)));
                        q.push_back(8'($urandom));
                    end
                    default: q.push_back(8'hC0 | 8'($urandom_range(0, 61)));
                endcase
            end
            model(q, px, endo);
            n = $urandom_range(0, px.size());
            e = {};
            for (int k = 0; k < n; k++) e.push_back(px[k]);
            used = (n == 0) ? 0 : endo[n-1];
            run_img("random", q, n, e, used, int'($urandom_range(0, 1)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
